// File: rtl/nand_pkg.sv
// Shared NAND sequencer definitions: FSM state encoding, ONFI opcodes and the
// pin bundle that every sequencer state decodes to.
package nand_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_CMD,
        ST_WE_LO,
        ST_WE_HI,
        ST_TWB,
        ST_WAIT_RB,
        ST_DONE,
        ST_ERR
    } nand_state_e;

    localparam logic [7:0] NAND_CMD_RESET = 8'hFF;

    typedef struct packed {
        logic       ce_n;
        logic       cle;
        logic       ale;
        logic       we_n;
        logic       re_n;
        logic [7:0] dq_out;
        logic       dq_oe;
        logic       busy;
        logic       ready;
        logic       err;
    } nand_pins_t;

    localparam nand_pins_t PINS_RESET = '{
        ce_n:   1'b1,
        cle:    1'b0,
        ale:    1'b0,
        we_n:   1'b1,
        re_n:   1'b1,
        dq_out: 8'h00,
        dq_oe:  1'b0,
        busy:   1'b0,
        ready:  1'b0,
        err:    1'b0
    };

    // Moore decode: the pin values the sequencer presents while in a state.
    function automatic nand_pins_t decode_outputs(input nand_state_e st);
        nand_pins_t p;
        p = PINS_RESET;
        case (st)
            ST_PWRUP: begin
                p.busy = 1'b1;
            end
            ST_CMD, ST_WE_HI: begin
                p.ce_n   = 1'b0;
                p.cle    = 1'b1;
                p.dq_out = NAND_CMD_RESET;
                p.dq_oe  = 1'b1;
                p.busy   = 1'b1;
            end
            ST_WE_LO: begin
                p.ce_n   = 1'b0;
                p.cle    = 1'b1;
                p.we_n   = 1'b0;
                p.dq_out = NAND_CMD_RESET;
                p.dq_oe  = 1'b1;
                p.busy   = 1'b1;
            end
            ST_TWB, ST_WAIT_RB: begin
                p.ce_n = 1'b0;
                p.busy = 1'b1;
            end
            ST_DONE: begin
                p.ready = 1'b1;
            end
            ST_ERR: begin
                p.err = 1'b1;
            end
            default: begin
                p = PINS_RESET;
            end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value
// so the synchronized output can start in its safe state.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/nand_reset_seq.sv
// Issues the ONFI RESET command after power-up (or on request) and waits for
// R/B# to report ready, flagging a timeout if the device never comes back.
module nand_reset_seq
    import nand_pkg::*;
#(
    parameter int PWRUP_CYC   = 2500,
    parameter int WE_LOW_CYC  = 2,
    parameter int WE_HIGH_CYC = 2,
    parameter int TWB_CYC     = 10,
    parameter int TIMEOUT_CYC = 50000,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       nand_rb_n,
    output logic       nand_ce_n,
    output logic       nand_cle,
    output logic       nand_ale,
    output logic       nand_we_n,
    output logic       nand_re_n,
    output logic [7:0] nand_dq_out,
    output logic       nand_dq_oe,
    output logic       busy,
    output logic       ready,
    output logic       err
);

    localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] WE_LO_LAST   = CNT_W'(WE_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] WE_HI_LAST   = CNT_W'(WE_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] TWB_LAST     = CNT_W'(TWB_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    nand_state_e      state_q;
    nand_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    nand_pins_t       pins_q;
    nand_pins_t       pins_d;
    logic             rb_sync;

    // Resets to busy so a floating or early-high R/B# cannot fake readiness.
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_rb_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (nand_rb_n),
        .q     (rb_sync)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PWRUP: begin
                if (cnt_q == PWRUP_LAST) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                state_d = ST_WE_LO;
            end
            ST_WE_LO: begin
                if (cnt_q == WE_LO_LAST) begin
                    state_d = ST_WE_HI;
                end
            end
            ST_WE_HI: begin
                if (cnt_q == WE_HI_LAST) begin
                    state_d = ST_TWB;
                end
            end
            ST_TWB: begin
                if (cnt_q == TWB_LAST) begin
                    state_d = ST_WAIT_RB;
                end
            end
            ST_WAIT_RB: begin
                // A ready seen on the final timeout cycle still counts as success.
                if (rb_sync) begin
                    state_d = ST_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_CMD;
                end
            end
            default: begin
                state_d = ST_PWRUP;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        pins_d = decode_outputs(state_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_PWRUP;
            cnt_q   <= '0;
            pins_q  <= PINS_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pins_q  <= pins_d;
        end
    end

    assign nand_ce_n   = pins_q.ce_n;
    assign nand_cle    = pins_q.cle;
    assign nand_ale    = pins_q.ale;
    assign nand_we_n   = pins_q.we_n;
    assign nand_re_n   = pins_q.re_n;
    assign nand_dq_out = pins_q.dq_out;
    assign nand_dq_oe  = pins_q.dq_oe;
    assign busy        = pins_q.busy;
    assign ready       = pins_q.ready;
    assign err         = pins_q.err;

endmodule
